// File: rtl/gate_quiz_core.sv
// gate_quiz_core
//   Registered WIDTH-bit bitwise gate unit (manual path) plus a quiz
//   sequencer that walks every (op, a, b) combination, waits for an answer
//   per step with an optional timeout, and keeps a score.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   global enable; low freezes all state
//   a, b, op              manual operands and opcode
//   result                registered f(op, a, b); 0 while ena is low
//   start                 begins a quiz from IDLE or DONE
//   guess_valid, guess    answer strobe and value (accepted only in WAIT)
//   op_out, a_out, b_out  quiz step presented ({op_out, a_out, b_out} = step)
//   guess_ready           high in WAIT (and ena high)
//   correct, wrong        1-cycle feedback pulses
//   score                 count of correct answers
//   busy, done            FSM activity / quiz complete
//
// Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 pass b.
module gate_quiz_core #(
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  input  logic                 start,
  input  logic                 guess_valid,
  input  logic [WIDTH-1:0]     guess,
  output logic [WIDTH-1:0]     result,
  output logic [2:0]           op_out,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 guess_ready,
  output logic                 correct,
  output logic                 wrong,
  output logic [2*WIDTH+3:0]   score,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = 2*WIDTH + 3;
  localparam int CW = 2*WIDTH + 4;
  // At least one bit, and wide enough to hold TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_WAIT,
    S_FEEDBACK,
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] gate_f(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (f_op)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = y;
    endcase
    return r;
  endfunction

  state_t           state;
  logic [SW-1:0]    step;
  logic [TW-1:0]    tcnt;
  logic [TW-1:0]    tcnt_nxt;
  logic             correct_q;
  logic             wrong_q;
  logic [WIDTH-1:0] expected;

  assign {op_out, a_out, b_out} = step;
  assign expected = gate_f(op_out, a_out, b_out);
  assign tcnt_nxt = tcnt + TW'(1);

  // Manual path, independent of the quiz FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   result <= '0;
    else if (ena) result <= gate_f(op, a, b);
    else          result <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step      <= '0;
      score     <= '0;
      tcnt      <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else if (ena) begin
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            step  <= '0;
            score <= '0;
            state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (guess_valid) begin
            state <= S_FEEDBACK;
            if (guess == expected) begin
              correct_q <= 1'b1;
              score     <= score + CW'(1);
            end else begin
              wrong_q <= 1'b1;
            end
          end else begin
            tcnt <= tcnt_nxt;
            if (TIMEOUT != 0 && tcnt_nxt == TLIM) begin
              state   <= S_FEEDBACK;
              wrong_q <= 1'b1;
            end
          end
        end
        S_FEEDBACK: begin
          if (&step) begin
            state <= S_DONE;
          end else begin
            step  <= step + SW'(1);
            state <= S_PRESENT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and feedback are masked while disabled; the pulse registers
  // themselves hold with the rest of the frozen state.
  assign guess_ready = ena && (state == S_WAIT);
  assign correct     = ena && correct_q;
  assign wrong       = ena && wrong_q;
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_gate_quiz_core.sv
module tb_gate_quiz_core;

  localparam int W  = 2;
  localparam int CW = 2*W + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [W-1:0]  a, b, guess;
  logic [2:0]    op;
  logic          start, guess_valid;
  logic [W-1:0]  result, a_out, b_out;
  logic [2:0]    op_out;
  logic          guess_ready, correct, wrong, busy, done;
  logic [CW-1:0] score;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_score;

  gate_quiz_core #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a(a), .b(b), .op(op),
    .start(start), .guess_valid(guess_valid), .guess(guess),
    .result(result), .op_out(op_out), .a_out(a_out), .b_out(b_out),
    .guess_ready(guess_ready), .correct(correct), .wrong(wrong),
    .score(score), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference gate model.
  function automatic logic [W-1:0] model(input logic [2:0] m_op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (m_op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return y;
    endcase
  endfunction

  // Wait (bounded) for WAIT, then answer step s; miss flips the answer.
  task automatic do_step(input int unsigned s, input bit miss);
    logic [6:0]   sv;
    logic [W-1:0] e, g;
    bit           seen;
    sv = 7'(s);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (guess_ready) seen = 1;
    end
    check("wait_ready", 32'(seen), 32'd1);
    check("step_shown", {25'd0, op_out, a_out, b_out}, 32'(sv));
    e = model(sv[6:4], sv[3:2], sv[1:0]);
    g = miss ? (e ^ 2'b01) : e;
    guess = g;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    if (!miss) exp_score++;
    check("fb_correct", 32'(correct), 32'(!miss));
    check("fb_wrong",   32'(wrong),   32'(miss));
    check("fb_score",   32'(score),   exp_score);
  endtask

  typedef struct { logic [2:0] o; logic [W-1:0] r; } man_t;
  man_t man_vec[8] = '{
    '{3'd0, 2'b10}, '{3'd1, 2'b11}, '{3'd2, 2'b01}, '{3'd3, 2'b01},
    '{3'd4, 2'b00}, '{3'd5, 2'b10}, '{3'd6, 2'b01}, '{3'd7, 2'b11}
  };

  initial begin
    rst_n = 1'b0; ena = 1'b0; a = '0; b = '0; op = '0;
    start = 1'b0; guess_valid = 1'b0; guess = '0;
    #1;
    check("rst_result", 32'(result), 0);
    check("rst_step", {25'd0, op_out, a_out, b_out}, 0);
    check("rst_flags", {guess_ready, correct, wrong, busy, done}, 0);
    check("rst_score", 32'(score), 0);
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;

    // Manual path: a=10, b=11.
    a = 2'b10; b = 2'b11;
    foreach (man_vec[i]) begin
      op = man_vec[i].o;
      @(negedge clk);
      check($sformatf("manual_op%0d", man_vec[i].o), 32'(result), 32'(man_vec[i].r));
    end

    // start -> PRESENT -> WAIT
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("present_busy", {busy, guess_ready}, 32'b10);
    @(negedge clk);
    check("wait_ready0", 32'(guess_ready), 1);
    check("wait_step0", {25'd0, op_out, a_out, b_out}, 0);
    guess = 2'b00; guess_valid = 1'b1;
    @(negedge clk);
    check("hs_correct", {correct, wrong}, 32'b10);
    check("hs_score", 32'(score), 1);
    check("fb_not_ready", 32'(guess_ready), 0);
    guess = 2'b11;                   // held through FEEDBACK and PRESENT
    @(negedge clk);
    check("next_step", {25'd0, op_out, a_out, b_out}, 1);
    check("pulse_1cyc", {correct, wrong}, 0);
    @(negedge clk);
    guess_valid = 1'b0;
    check("ignored_score", 32'(score), 1);
    check("ignored_ready", {guess_ready, wrong}, 32'b10);

    // Timeout: 8 WAIT cycles, then wrong.
    repeat (7) @(negedge clk);
    check("to_still_wait", {guess_ready, wrong}, 32'b10);
    @(negedge clk);
    check("to_wrong", {correct, wrong, guess_ready}, 32'b010);
    check("to_score", 32'(score), 1);
    @(negedge clk);
    check("to_advance", {25'd0, op_out, a_out, b_out}, 2);
    @(negedge clk);
    check("to_wait2", 32'(guess_ready), 1);

    // ena=0 mid-WAIT with a would-be-correct answer offered.
    ena = 1'b0; guess = 2'b00; guess_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ena0_result", 32'(result), 0);
      check("ena0_flags", {guess_ready, correct, wrong}, 0);
      check("ena0_step", {25'd0, op_out, a_out, b_out}, 2);
      check("ena0_score", 32'(score), 1);
    end
    guess_valid = 1'b0; ena = 1'b1;
    @(negedge clk);
    check("ena1_resume", {guess_ready, busy}, 32'b11);
    check("ena1_step", {25'd0, op_out, a_out, b_out}, 2);

    // Full run from a clean reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_score = 0;
    for (int unsigned s = 0; s < 128; s++) do_step(s, (s == 5 || s == 77));
    @(negedge clk);
    check("run_done", {done, busy}, 32'b10);
    check("run_score", 32'(score), 126);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_flags", {done, busy}, 32'b01);
    check("restart_score", 32'(score), 0);
    check("restart_step", {25'd0, op_out, a_out, b_out}, 0);

    // Reset mid-WAIT at step 40.
    exp_score = 0;
    for (int unsigned s = 0; s < 40; s++) do_step(s, 1'b0);
    for (int i = 0; i < 12 && !guess_ready; i++) @(negedge clk);
    check("s40_ready", 32'(guess_ready), 1);
    check("s40_step", {25'd0, op_out, a_out, b_out}, 40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 32'(result), 0);
    check("arst_step", {25'd0, op_out, a_out, b_out}, 0);
    check("arst_flags", {guess_ready, correct, wrong, busy, done}, 0);
    check("arst_score", 32'(score), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", {busy, done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
